// File: rtl/rx_cmd_parser_if.sv
// rtl/rx_cmd_parser_if.sv - byte stream in, {A, B, Op} command out, valid/ack handshake
interface rx_cmd_parser_if #(
    parameter int DBIT    = 8,
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
);
    logic               rx_done_tick;
    logic [DBIT-1:0]    dout;
    logic               cmd_ack;
    logic [NB_DATA-1:0] A;
    logic [NB_DATA-1:0] B;
    logic [NB_OP-1:0]   Op;
    logic               cmd_valid;
    logic [3:0]         err;

    modport master (
        output rx_done_tick, dout, cmd_ack,
        input  A, B, Op, cmd_valid, err
    );

    modport slave (
        input  rx_done_tick, dout, cmd_ack,
        output A, B, Op, cmd_valid, err
    );
endinterface

// File: rtl/rx_cmd_parser.sv
// rtl/rx_cmd_parser.sv - ASCII command parser: decimal operands, operator symbol, held command
module rx_cmd_parser #(
    parameter int DBIT       = 8,
    parameter int NB_DATA    = 8,
    parameter int NB_OP      = 6,
    parameter int MAX_DIGITS = 3
) (
    input  logic          clk,
    input  logic          reset,
    rx_cmd_parser_if.slave bus
);
    localparam int AW = NB_DATA + 4;
    localparam int PW = AW + 4;
    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam logic [PW-1:0] MAXV = {{(PW-NB_DATA){1'b0}}, {NB_DATA{1'b1}}};

    typedef enum logic {COLLECT, HOLD} state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      acc_q, acc_d;
    logic [CW-1:0]      digit_cnt_q, digit_cnt_d;
    logic [7:0]         op_char_q, op_char_d;
    logic [NB_DATA-1:0] a_q, a_d, b_q, b_d;
    logic [NB_OP-1:0]   op_q, op_d;
    logic               valid_q, valid_d;
    logic [3:0]         err_q, err_d;

    logic [7:0]    rx_byte;
    logic [PW-1:0] acc_next;

    assign rx_byte = bus.dout[7:0];
    // acc never exceeds MAXV, so acc*10+9 always fits in PW bits
    assign acc_next = {4'b0, acc_q} * PW'(10) + PW'(rx_byte - 8'd48);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= COLLECT;
            acc_q       <= '0;
            digit_cnt_q <= '0;
            op_char_q   <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            valid_q     <= 1'b0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            digit_cnt_q <= digit_cnt_d;
            op_char_q   <= op_char_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        digit_cnt_d = digit_cnt_q;
        op_char_d   = op_char_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        valid_d     = valid_q;
        err_d       = err_q;

        case (state_q)
            COLLECT: begin
                if (bus.rx_done_tick) begin
                    if (rx_byte >= 8'd48 && rx_byte <= 8'd57) begin
                        if (digit_cnt_q == CW'(MAX_DIGITS)) begin
                            err_d[0] = 1'b1;
                        end else begin
                            digit_cnt_d = digit_cnt_q + 1'b1;
                            if (acc_next > MAXV) begin
                                acc_d    = AW'(MAXV);
                                err_d[1] = 1'b1;
                            end else begin
                                acc_d = AW'(acc_next);
                            end
                        end
                    end else begin
                        case (rx_byte)
                            8'd102: begin
                                a_d         = acc_q[NB_DATA-1:0];
                                acc_d       = '0;
                                digit_cnt_d = '0;
                            end
                            8'd115: begin
                                b_d         = acc_q[NB_DATA-1:0];
                                acc_d       = '0;
                                digit_cnt_d = '0;
                            end
                            8'd111: begin
                                op_char_d = '0;
                                case (op_char_q)
                                    8'd43:   op_d = NB_OP'(32);
                                    8'd45:   op_d = NB_OP'(34);
                                    8'd38:   op_d = NB_OP'(36);
                                    8'd124:  op_d = NB_OP'(37);
                                    8'd120:  op_d = NB_OP'(38);
                                    8'd97:   op_d = NB_OP'(3);
                                    8'd108:  op_d = NB_OP'(2);
                                    8'd110:  op_d = NB_OP'(39);
                                    default: begin
                                        op_d     = '1;
                                        err_d[2] = 1'b1;
                                    end
                                endcase
                            end
                            8'd100: begin
                                valid_d = 1'b1;
                                state_d = HOLD;
                            end
                            8'd99: begin
                                a_d         = '0;
                                b_d         = '0;
                                op_d        = '0;
                                acc_d       = '0;
                                digit_cnt_d = '0;
                                op_char_d   = '0;
                                err_d       = '0;
                            end
                            8'd13, 8'd10, 8'd32: ;
                            default: op_char_d = rx_byte;
                        endcase
                    end
                end
            end
            HOLD: begin
                // an ack wins over a coincident byte, which is then dropped silently
                if (bus.cmd_ack) begin
                    valid_d     = 1'b0;
                    a_d         = '0;
                    b_d         = '0;
                    op_d        = '0;
                    acc_d       = '0;
                    digit_cnt_d = '0;
                    op_char_d   = '0;
                    err_d       = '0;
                    state_d     = COLLECT;
                end else if (bus.rx_done_tick) begin
                    err_d[3] = 1'b1;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    assign bus.A         = a_q;
    assign bus.B         = b_q;
    assign bus.Op        = op_q;
    assign bus.cmd_valid = valid_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_rx_cmd_parser.sv
// tb/tb_rx_cmd_parser.sv - directed and randomized byte streams against a behavioural command model
module tb_rx_cmd_parser;
    localparam int DBIT       = 8;
    localparam int NB_DATA    = 8;
    localparam int NB_OP      = 6;
    localparam int MAX_DIGITS = 3;
    localparam int MAXV       = (1 << NB_DATA) - 1;

    logic clk;
    logic reset;

    rx_cmd_parser_if #(.DBIT(DBIT), .NB_DATA(NB_DATA), .NB_OP(NB_OP)) bus ();

    rx_cmd_parser #(
        .DBIT(DBIT), .NB_DATA(NB_DATA), .NB_OP(NB_OP), .MAX_DIGITS(MAX_DIGITS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    int m_a, m_b, m_op, m_acc, m_cnt, m_opc, m_err;
    bit m_valid, m_hold;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int decode(input int c);
        case (c)
            43:      return 32;
            45:      return 34;
            38:      return 36;
            124:     return 37;
            120:     return 38;
            97:      return 3;
            108:     return 2;
            110:     return 39;
            default: return -1;
        endcase
    endfunction

    task automatic model_clear();
        m_a = 0; m_b = 0; m_op = 0; m_acc = 0; m_cnt = 0; m_opc = 0; m_err = 0;
        m_valid = 0; m_hold = 0;
    endtask

    task automatic model_apply(input int b, input bit tick, input bit ack);
        int d;
        if (m_hold) begin
            if (ack) model_clear();
            else if (tick) m_err = m_err | 8;
        end else if (tick) begin
            if (b >= 48 && b <= 57) begin
                if (m_cnt == MAX_DIGITS) begin
                    m_err = m_err | 1;
                end else begin
                    m_cnt++;
                    m_acc = m_acc * 10 + (b - 48);
                    if (m_acc > MAXV) begin
                        m_acc = MAXV;
                        m_err = m_err | 2;
                    end
                end
            end else if (b == 102) begin
                m_a = m_acc; m_acc = 0; m_cnt = 0;
            end else if (b == 115) begin
                m_b = m_acc; m_acc = 0; m_cnt = 0;
            end else if (b == 111) begin
                d = decode(m_opc);
                if (d < 0) begin
                    m_op = (1 << NB_OP) - 1;
                    m_err = m_err | 4;
                end else begin
                    m_op = d;
                end
                m_opc = 0;
            end else if (b == 100) begin
                m_valid = 1; m_hold = 1;
            end else if (b == 99) begin
                model_clear();
            end else if (b == 13 || b == 10 || b == 32) begin
            end else begin
                m_opc = b;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_A"},     32'(bus.A),         32'(m_a));
        check({tag, "_B"},     32'(bus.B),         32'(m_b));
        check({tag, "_Op"},    32'(bus.Op),        32'(m_op));
        check({tag, "_valid"}, 32'(bus.cmd_valid), 32'(m_valid));
        check({tag, "_err"},   32'(bus.err),       32'(m_err));
    endtask

    task automatic step(input int b, input bit tick, input bit ack, input string tag);
        @(negedge clk);
        bus.rx_done_tick = tick;
        bus.dout         = 8'(b);
        bus.cmd_ack      = ack;
        @(posedge clk);
        #1;
        model_apply(b, tick, ack);
        bus.rx_done_tick = 1'b0;
        bus.cmd_ack      = 1'b0;
        compare_all(tag);
    endtask

    task automatic send_str(input string s, input string tag);
        for (int i = 0; i < s.len(); i++) step(int'(s[i]), 1'b1, 1'b0, tag);
    endtask

    task automatic pulse_reset(input string tag);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        model_clear();
        compare_all(tag);
        @(negedge clk);
        reset = 1'b1;
    endtask

    int r, b;
    bit tick, ack;
    byte opchars [8] = '{8'd43, 8'd45, 8'd38, 8'd124, 8'd120, 8'd97, 8'd108, 8'd110};

    initial begin
        vectors = 0;
        miscompares = 0;
        bus.rx_done_tick = 1'b0;
        bus.dout = '0;
        bus.cmd_ack = 1'b0;
        reset = 1'b0;
        model_clear();
        #12;
        compare_all("reset");
        reset = 1'b1;

        send_str("12f34s+od", "basic");
        check("basic_A_const",  32'(bus.A),         32'd12);
        check("basic_B_const",  32'(bus.B),         32'd34);
        check("basic_Op_const", 32'(bus.Op),        32'd32);
        check("basic_valid",    32'(bus.cmd_valid), 32'd1);
        step(0, 1'b0, 1'b1, "ack");
        check("ack_valid_const", 32'(bus.cmd_valid), 32'd0);

        send_str("300f", "sat");
        check("sat_A_const",   32'(bus.A),   32'd255);
        check("sat_err_const", 32'(bus.err), 32'd2);
        send_str("c1234f", "digits");
        check("digits_A_const",   32'(bus.A),   32'd123);
        check("digits_err_const", 32'(bus.err), 32'd1);

        send_str("?o", "badop");
        check("badop_Op_const", 32'(bus.Op),        32'd63);
        check("badop_err_bit",  32'(bus.err[2]),    32'd1);
        send_str("c", "clear");
        check("clear_err_const", 32'(bus.err), 32'd0);

        send_str("12f34s+odd5", "drop");
        check("drop_A_const",   32'(bus.A),   32'd12);
        check("drop_err_const", 32'(bus.err), 32'd8);
        step(53, 1'b1, 1'b1, "drop_ack");
        check("drop_ack_err", 32'(bus.err), 32'd0);
        send_str("f", "drop_noeffect");

        send_str("7 f\r\n9sxod", "ws");
        check("ws_A_const",  32'(bus.A),  32'd7);
        check("ws_B_const",  32'(bus.B),  32'd9);
        check("ws_Op_const", 32'(bus.Op), 32'd38);
        step(0, 1'b0, 1'b1, "ws_ack");

        send_str("45", "rst_mid");
        pulse_reset("rst_mid_reset");
        send_str("6f", "rst_after");
        check("rst_after_A_const", 32'(bus.A), 32'd6);

        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 99);
            if (r < 40)      b = 48 + $urandom_range(0, 9);
            else if (r < 48) b = 102;
            else if (r < 56) b = 115;
            else if (r < 64) b = 111;
            else if (r < 68) b = 100;
            else if (r < 70) b = 99;
            else if (r < 74) b = (r == 70) ? 13 : (r == 71) ? 10 : 32;
            else if (r < 88) b = int'(opchars[$urandom_range(0, 7)]);
            else             b = $urandom_range(0, 255);
            tick = ($urandom_range(0, 4) != 0);
            ack  = m_hold ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 149) == 0) pulse_reset("rand_reset");
            else step(b, tick, ack, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
